// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer: parallel word in, serial bit stream and strobes out.
interface piso_serializer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_data;
  logic             data_ena;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, serial_data, data_ena, busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, serial_data, data_ena, busy, frame_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: LSB-first bit stream, one data_ena strobe per bit,
// CLK_DIV clk cycles per bit, back-to-back words accepted on the last bit's strobe.
module piso_serializer #(
  parameter int WIDTH   = 2,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_strobe;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

  // Everything visible outside is decoded from registers only, so no input reaches an output.
  assign w_strobe = (r_state == S_SHIFT) && (r_div == DIV_LAST);
  assign w_last   = w_strobe && (r_bit == BIT_LAST);
  assign w_ready  = (r_state == S_IDLE) || w_last;
  assign w_accept = bus.in_valid && w_ready;

  assign bus.in_ready    = w_ready;
  assign bus.serial_data = (r_state == S_SHIFT) && r_shreg[0];
  assign bus.data_ena    = w_strobe;
  assign bus.busy        = (r_state == S_SHIFT);
  assign bus.frame_done  = w_last;

  // Next-state logic: load on accept, shift on strobe, otherwise advance the divider.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = bus.in_data;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_strobe) begin
          // In SHIFT an accept can only happen on the last strobe, so it is a reload.
          if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_shreg_nxt = bus.in_data;
            w_bit_nxt   = '0;
            w_div_nxt   = '0;
          end else if (w_last) begin
            w_state_nxt = S_IDLE;
            w_shreg_nxt = '0;
            w_bit_nxt   = '0;
            w_div_nxt   = '0;
          end else begin
            w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_div_nxt   = '0;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shreg_nxt = '0;
        w_bit_nxt   = '0;
        w_div_nxt   = '0;
      end
    endcase
  end

  // State, shift register and counters; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_bit   <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed checks of piso_serializer framing, divider, backpressure and reset, plus a
// scoreboarded random run on WIDTH=8 instances with CLK_DIV 1..4.
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_d, rst_s;
  logic stress_go = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  piso_serializer_if #(.WIDTH(2)) if_a ();
  piso_serializer_if #(.WIDTH(2)) if_b ();
  piso_serializer_if #(.WIDTH(8)) if_d ();

  piso_serializer #(.WIDTH(2), .CLK_DIV(1)) u_dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  piso_serializer #(.WIDTH(2), .CLK_DIV(3)) u_dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
  piso_serializer #(.WIDTH(8), .CLK_DIV(1)) u_dut_d (.clk(clk), .reset(rst_d), .bus(if_d));

  logic [4:0] obs_a, obs_b, obs_d;
  assign obs_a = {if_a.serial_data, if_a.data_ena, if_a.frame_done, if_a.busy, if_a.in_ready};
  assign obs_b = {if_b.serial_data, if_b.data_ena, if_b.frame_done, if_b.busy, if_b.in_ready};
  assign obs_d = {if_d.serial_data, if_d.data_ena, if_d.frame_done, if_d.busy, if_d.in_ready};

  // Downstream right-shifting registers (new bit enters at MSB) and strobe counters.
  logic [1:0] ds_a = 2'b00;
  logic [1:0] ds_b = 2'b00;
  logic [7:0] ds_d = 8'h00;
  int cnt_a = 0;
  int cnt_b = 0;
  int cnt_d = 0;
  always @(posedge clk) begin
    if (if_a.data_ena) ds_a <= {if_a.serial_data, ds_a[1]};
    if (if_b.data_ena) ds_b <= {if_b.serial_data, ds_b[1]};
    if (if_d.data_ena) ds_d <= {if_d.serial_data, ds_d[7:1]};
    cnt_a <= cnt_a + (if_a.data_ena ? 1 : 0);
    cnt_b <= cnt_b + (if_b.data_ena ? 1 : 0);
    cnt_d <= cnt_d + (if_d.data_ena ? 1 : 0);
  end

  for (genvar g = 1; g <= 4; g++) begin : g_st
    piso_serializer_if #(.WIDTH(8)) if_s ();
    piso_serializer #(.WIDTH(8), .CLK_DIV(g)) u_dut (.clk(clk), .reset(rst_s), .bus(if_s));
    logic [7:0] ds = 8'h00;
    logic [7:0] exp_q [$];
    int   cnt = 0;
    logic done_g = 1'b0;

    always @(posedge clk) begin
      if (if_s.data_ena) ds <= {if_s.serial_data, ds[7:1]};
      cnt <= cnt + (if_s.data_ena ? 1 : 0);
    end

    initial begin : drv
      logic [7:0] w;
      int t;
      int gap;
      if_s.in_data  = 8'h00;
      if_s.in_valid = 1'b0;
      wait (stress_go);
      @(negedge clk);
      for (int n = 0; n < 250; n++) begin
        gap = int'($urandom_range(0, 3));
        if_s.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        w = 8'($urandom);
        if_s.in_data  = w;
        if_s.in_valid = 1'b1;
        t = 0;
        while (!if_s.in_ready && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (t >= 200) check_val("stress_accept_timeout", t, 0);
        exp_q.push_back(w);
        @(negedge clk);
      end
      if_s.in_valid = 1'b0;
      repeat (40) @(negedge clk);
      check_val("stress_ena_count", cnt, 8 * 250);
      check_val("stress_words_left", exp_q.size(), 0);
      done_g = 1'b1;
    end

    initial begin : mon
      logic [7:0] got;
      forever begin
        @(negedge clk);
        if (if_s.frame_done) begin
          got = {if_s.serial_data, ds[7:1]};
          if (exp_q.size() == 0) check_val("stress_extra_word", exp_q.size(), 1);
          else check_val("stress_word", got, exp_q.pop_front());
        end
      end
    end
  end

  logic [3:0] w_done;
  assign w_done = {g_st[4].done_g, g_st[3].done_g, g_st[2].done_g, g_st[1].done_g};

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int t;
    logic [7:0] w8;
    rst_a = 1'b1; rst_b = 1'b1; rst_d = 1'b1; rst_s = 1'b1;
    if_a.in_data = 2'b00; if_a.in_valid = 1'b0;
    if_b.in_data = 2'b00; if_b.in_valid = 1'b0;
    if_d.in_data = 8'h00; if_d.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_a", obs_a, 5'b00001);
    check_val("rst_b", obs_b, 5'b00001);
    check_val("rst_d", obs_d, 5'b00001);

    // Single word, accepted on the first edge after reset release.
    rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0; rst_s = 1'b0;
    if_a.in_data = 2'b10; if_a.in_valid = 1'b1;
    @(negedge clk); check_val("t1_c1", obs_a, 5'b01010); if_a.in_valid = 1'b0;
    @(negedge clk); check_val("t1_c2", obs_a, 5'b11111);
    @(negedge clk); check_val("t1_c3", obs_a, 5'b00001);
    check_val("t1_word", ds_a, 2'b10);

    // Back-to-back 01 then 11 with in_valid held high.
    c0 = cnt_a;
    if_a.in_data = 2'b01; if_a.in_valid = 1'b1;
    @(negedge clk); check_val("t2_c1", obs_a, 5'b11010); if_a.in_data = 2'b11;
    @(negedge clk); check_val("t2_c2", obs_a, 5'b01111);
    @(negedge clk); check_val("t2_c3", obs_a, 5'b11010); check_val("t2_word1", ds_a, 2'b01);
    if_a.in_valid = 1'b0;
    @(negedge clk); check_val("t2_c4", obs_a, 5'b11111);
    @(negedge clk); check_val("t2_c5", obs_a, 5'b00001); check_val("t2_word2", ds_a, 2'b11);
    check_val("t2_ena_count", cnt_a - c0, 4);

    // Divider: CLK_DIV=3, word 01.
    if_b.in_data = 2'b01; if_b.in_valid = 1'b1;
    @(negedge clk); check_val("t3_c1", obs_b, 5'b10010); if_b.in_valid = 1'b0;
    @(negedge clk); check_val("t3_c2", obs_b, 5'b10010);
    @(negedge clk); check_val("t3_c3", obs_b, 5'b11010);
    @(negedge clk); check_val("t3_c4", obs_b, 5'b00010);
    @(negedge clk); check_val("t3_c5", obs_b, 5'b00010);
    @(negedge clk); check_val("t3_c6", obs_b, 5'b01111);
    @(negedge clk); check_val("t3_c7", obs_b, 5'b00001); check_val("t3_word", ds_b, 2'b01);

    // Backpressure: 11 held pending while 10 is shifting out.
    c0 = cnt_b;
    if_b.in_data = 2'b10; if_b.in_valid = 1'b1;
    @(negedge clk); check_val("t4_c1", obs_b, 5'b00010); if_b.in_data = 2'b11;
    @(negedge clk); check_val("t4_c2", obs_b, 5'b00010);
    @(negedge clk); check_val("t4_c3", obs_b, 5'b01010);
    @(negedge clk); check_val("t4_c4", obs_b, 5'b10010);
    @(negedge clk); check_val("t4_c5", obs_b, 5'b10010);
    @(negedge clk); check_val("t4_c6", obs_b, 5'b11111);
    @(negedge clk); check_val("t4_c7", obs_b, 5'b10010); check_val("t4_word1", ds_b, 2'b10);
    if_b.in_valid = 1'b0;
    @(negedge clk); check_val("t4_c8", obs_b, 5'b10010);
    @(negedge clk); check_val("t4_c9", obs_b, 5'b11010);
    @(negedge clk); check_val("t4_c10", obs_b, 5'b10010);
    @(negedge clk); check_val("t4_c11", obs_b, 5'b10010);
    @(negedge clk); check_val("t4_c12", obs_b, 5'b11111);
    @(negedge clk); check_val("t4_c13", obs_b, 5'b00001); check_val("t4_word2", ds_b, 2'b11);
    check_val("t4_ena_count", cnt_b - c0, 4);

    // Reset after three strobes of A5, then 3C from bit 0.
    c0 = cnt_d;
    if_d.in_data = 8'hA5; if_d.in_valid = 1'b1;
    @(negedge clk); check_val("t5_c1", obs_d, 5'b11010); if_d.in_valid = 1'b0;
    @(negedge clk); check_val("t5_c2", obs_d, 5'b01010);
    @(negedge clk); check_val("t5_c3", obs_d, 5'b11010);
    @(negedge clk); rst_d = 1'b1;
    #1; check_val("t5_rst_now", obs_d, 5'b00001); check_val("t5_rst_ena", cnt_d - c0, 3);
    @(negedge clk); check_val("t5_rst_hold", obs_d, 5'b00001);
    check_val("t5_rst_no_ena", cnt_d - c0, 3);
    rst_d = 1'b0;
    w8 = 8'h3C;
    if_d.in_data = w8; if_d.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t5_bit", {if_d.serial_data, if_d.data_ena}, {w8[i], 1'b1});
      if_d.in_valid = 1'b0;
    end
    @(negedge clk); check_val("t5_idle", obs_d, 5'b00001);
    check_val("t5_word", ds_d, 8'h3C);
    check_val("t5_ena_total", cnt_d - c0, 11);

    // Random stress on CLK_DIV 1..4.
    stress_go = 1'b1;
    t = 0;
    while (w_done != 4'hF && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check_val("stress_done", w_done, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
